// File: rtl/knn_topk_sorter_if.sv
// Sample stream into the top-K sorter: distance, class label and end-of-stream
// marker, moved under a valid/ready handshake.
interface knn_topk_sorter_if #(
  parameter int W     = 32,
  parameter int LBL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_dist;
  logic [LBL_W-1:0] in_label;
  logic             in_last;

  modport master (
    output in_valid, in_dist, in_label, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_dist, in_label, in_last,
    output in_ready
  );
endinterface

// File: rtl/knn_topk_sorter.sv
// Streaming insertion sorter keeping the K smallest distances (with index and
// label) in ascending order, plus end-of-stream FSM and random-access readout.
module knn_topk_sorter #(
  parameter int W     = 32,
  parameter int K     = 4,
  parameter int IDX_W = 8,
  parameter int LBL_W = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  knn_topk_sorter_if.slave     stream,
  output logic                 done,
  output logic [SEL_W:0]       count,
  output logic                 idx_ovf,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic                 rd_valid,
  output logic [W-1:0]         rd_dist,
  output logic [IDX_W-1:0]     rd_idx,
  output logic [LBL_W-1:0]     rd_label
);

  localparam logic [SEL_W:0] CNT_MAX = (SEL_W+1)'(K);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_p1;
  logic             ready_p1;
  logic             done_p1;
  logic [SEL_W:0]   count_p1;
  logic [IDX_W-1:0] idx_cnt_p1;
  logic             ovf_p1;

  logic [K-1:0]     vld_p1;
  logic [W-1:0]     dist_p1 [K];
  logic [IDX_W-1:0] idx_p1  [K];
  logic [LBL_W-1:0] lbl_p1  [K];

  logic [K-1:0]     beaten;
  logic [K-1:0]     vld_nx;
  logic [W-1:0]     dist_nx [K];
  logic [IDX_W-1:0] idx_nx  [K];
  logic [LBL_W-1:0] lbl_nx  [K];

  logic accept;

  function automatic logic [SEL_W:0] sat_inc(input logic [SEL_W:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + (SEL_W+1)'(1);
  endfunction

  assign accept          = stream.in_valid & ready_p1;
  assign stream.in_ready = ready_p1;
  assign done            = done_p1;
  assign count           = count_p1;
  assign idx_ovf         = ovf_p1;

  // The list is a sorted valid prefix, so 'beaten' is monotone: the first set
  // bit is the insertion point and every later set bit shifts down by one.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      beaten[i]  = !vld_p1[i] || (stream.in_dist < dist_p1[i]);
      vld_nx[i]  = vld_p1[i];
      dist_nx[i] = dist_p1[i];
      idx_nx[i]  = idx_p1[i];
      lbl_nx[i]  = lbl_p1[i];
      if (beaten[i]) begin
        vld_nx[i]  = 1'b1;
        dist_nx[i] = stream.in_dist;
        idx_nx[i]  = idx_cnt_p1;
        lbl_nx[i]  = stream.in_label;
      end
    end
    for (int i = 1; i < K; i++) begin
      if (beaten[i-1] && beaten[i]) begin
        vld_nx[i]  = vld_p1[i-1];
        dist_nx[i] = dist_p1[i-1];
        idx_nx[i]  = idx_p1[i-1];
        lbl_nx[i]  = lbl_p1[i-1];
      end
    end
  end

  // Stage p1: slot list register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) begin
        vld_p1[i]  <= 1'b0;
        dist_p1[i] <= '1;
        idx_p1[i]  <= '0;
        lbl_p1[i]  <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < K; i++) begin
        vld_p1[i]  <= 1'b0;
        dist_p1[i] <= '1;
        idx_p1[i]  <= '0;
        lbl_p1[i]  <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        vld_p1[i]  <= vld_nx[i];
        dist_p1[i] <= dist_nx[i];
        idx_p1[i]  <= idx_nx[i];
        lbl_p1[i]  <= lbl_nx[i];
      end
    end
  end

  // Stage p1: stream FSM, counters and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1   <= IDLE;
      ready_p1   <= 1'b1;
      done_p1    <= 1'b0;
      count_p1   <= '0;
      idx_cnt_p1 <= '0;
      ovf_p1     <= 1'b0;
    end else if (clear) begin
      state_p1   <= IDLE;
      ready_p1   <= 1'b1;
      done_p1    <= 1'b0;
      count_p1   <= '0;
      idx_cnt_p1 <= '0;
      ovf_p1     <= 1'b0;
    end else begin
      case (state_p1)
        IDLE, ACCUM: begin
          if (accept) begin
            count_p1   <= sat_inc(count_p1);
            idx_cnt_p1 <= idx_cnt_p1 + IDX_W'(1);
            if (idx_cnt_p1 == '1) ovf_p1 <= 1'b1;
            if (stream.in_last) begin
              state_p1 <= DONE;
              ready_p1 <= 1'b0;
              done_p1  <= 1'b1;
            end else begin
              state_p1 <= ACCUM;
            end
          end
        end
        default: begin
          state_p1 <= DONE;
          ready_p1 <= 1'b0;
          done_p1  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_dist  = '0;
    rd_idx   = '0;
    rd_label = '0;
    for (int i = 0; i < K; i++) begin
      if (vld_p1[i] && (rd_sel == SEL_W'(i))) begin
        rd_valid = 1'b1;
        rd_dist  = dist_p1[i];
        rd_idx   = idx_p1[i];
        rd_label = lbl_p1[i];
      end
    end
  end

endmodule
